// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: merges the ALU and load writeback streams onto
// the single regfile write port and tracks pending destination writes for decode.
module rf_wb_arbiter #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int RR_EN = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_wR,
  input  logic [DW-1:0] req0_wD,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_wR,
  input  logic [DW-1:0] req1_wD,
  output logic          we,
  output logic [AW-1:0] wR,
  output logic [DW-1:0] wD,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_wR,
  input  logic [AW-1:0] chk_rR1,
  input  logic [AW-1:0] chk_rR2,
  output logic          stall,
  output logic          busy
);
  localparam int NR = 1 << AW;

  logic          lastGrant;
  logic          grant0;
  logic          grant1;
  logic [NR-1:0] pend;
  logic [NR-1:0] pendNext;

  // Handshake: a transfer happens when valid & ready on the same rising edge; the
  // requester keeps valid/wR/wD stable until ready. Ready depends only on the
  // valids and lastGrant, so at most one requester is granted per cycle.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if ((RR_EN != 0) && (lastGrant == 1'b0)) grant1 = 1'b1;
      else                                     grant0 = 1'b1;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Clear on the actual regfile write, then set from issue so a new producer of
  // the same register on the same edge keeps it pending.
  always_comb begin
    pendNext = pend;
    if (we) pendNext[wR] = 1'b0;
    if (iss_valid) pendNext[iss_wR] = 1'b1;
    pendNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we        <= 1'b0;
      wR        <= '0;
      wD        <= '0;
      lastGrant <= 1'b1;
      pend      <= '0;
    end else begin
      pend <= pendNext;
      if (grant0) begin
        we        <= (req0_wR != '0);
        wR        <= req0_wR;
        wD        <= req0_wD;
        lastGrant <= 1'b0;
      end else if (grant1) begin
        we        <= (req1_wR != '0);
        wR        <= req1_wR;
        wD        <= req1_wD;
        lastGrant <= 1'b1;
      end else begin
        we <= 1'b0;
      end
    end
  end

  assign stall = pend[chk_rR1] | pend[chk_rR2];
  assign busy  = |pend;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model of grants, writes and pending registers.
module tb_rf_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, iss_valid;
  logic [AW-1:0] req0_wR, req1_wR, iss_wR, chk_rR1, chk_rR2;
  logic [DW-1:0] req0_wD, req1_wD;
  logic          req0_ready, req1_ready, we, stall, busy;
  logic [AW-1:0] wR;
  logic [DW-1:0] wD;
  logic          d1_r0, d1_r1, d1_we, d1_stall, d1_busy;
  logic [AW-1:0] d1_wR;
  logic [DW-1:0] d1_wD;

  int n_pass = 0;
  int n_tot  = 0;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wR(req0_wR), .req0_wD(req0_wD),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wR(req1_wR), .req1_wD(req1_wD),
    .we(we), .wR(wR), .wD(wD),
    .iss_valid(iss_valid), .iss_wR(iss_wR), .chk_rR1(chk_rR1), .chk_rR2(chk_rR2),
    .stall(stall), .busy(busy)
  );

  rf_wb_arbiter #(.AW(AW), .DW(DW), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(d1_r0), .req0_wR(req0_wR), .req0_wD(req0_wD),
    .req1_valid(req1_valid), .req1_ready(d1_r1), .req1_wR(req1_wR), .req1_wD(req1_wD),
    .we(d1_we), .wR(d1_wR), .wD(d1_wD),
    .iss_valid(iss_valid), .iss_wR(iss_wR), .chk_rR1(chk_rR1), .chk_rR2(chk_rR2),
    .stall(d1_stall), .busy(d1_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // behavioural model: who wins, what gets written when, which registers are owed a write
  logic [31:0]       m_pend;
  int                m_last;      // index of the requester granted most recently
  logic              m_we;
  logic [AW-1:0]     m_wR;
  logic [DW-1:0]     m_wD;
  logic [AW+DW-1:0]  exp_q[$];
  logic [DW-1:0]     tb_rf[32];

  function automatic int winner(input logic v0, input logic v1, input int last, input bit rr);
    if (v0 && v1) return (rr && last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_last = 1; m_we = 1'b0; m_wR = '0; m_wD = '0;
      exp_q.delete();
    end else begin
      int w;
      if (m_we) m_pend[m_wR] = 1'b0;
      if (iss_valid && iss_wR != 0) m_pend[iss_wR] = 1'b1;
      w = winner(req0_valid, req1_valid, m_last, 1'b1);
      m_we = 1'b0;
      if (w >= 0) begin
        m_last = w;
        m_wR = (w == 0) ? req0_wR : req1_wR;
        m_wD = (w == 0) ? req0_wD : req1_wD;
        m_we = (m_wR != 0);
        if (m_we) exp_q.push_back({m_wR, m_wD});
      end
    end
  end

  // scoreboard: every regfile write must be the next expected one
  always @(posedge clk) begin
    if (rst_n && we) begin
      tb_rf[wR] <= wD;
      if (exp_q.size() == 0) chk("unexpected_write", {27'd0, wR, wD}, 64'd0);
      else chk("write_order", {27'd0, wR, wD}, {27'd0, exp_q.pop_front()});
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (rst_n) begin
      int w;
      w = winner(req0_valid, req1_valid, m_last, 1'b1);
      chk("req0_ready", req0_ready, w == 0);
      chk("req1_ready", req1_ready, w == 1);
      chk("fp_req0_ready", d1_r0, req0_valid);
      chk("fp_req1_ready", d1_r1, req1_valid && !req0_valid);
      chk("we", we, m_we);
      if (m_we) chk("wR_wD", {27'd0, wR, wD}, {27'd0, m_wR, m_wD});
      chk("stall", stall, m_pend[chk_rR1] | m_pend[chk_rR2]);
      chk("busy", busy, m_pend != 0);
    end
  end

  task automatic drive_random(input int n);
    logic x0, x1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      x0 = req0_valid & req0_ready;
      x1 = req1_valid & req1_ready;
      tick();
      if (!req0_valid || x0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_wR = AW'($urandom_range(0, 7));
        req0_wD = $urandom;
      end
      if (!req1_valid || x1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_wR = AW'($urandom_range(0, 7));
        req1_wD = $urandom;
      end
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_wR  = AW'($urandom_range(0, 7));
      chk_rR1 = AW'($urandom_range(0, 7));
      chk_rR2 = AW'($urandom_range(0, 7));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) tb_rf[i] = '0;
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0; iss_valid = 0;
    req0_wR = 0; req1_wR = 0; iss_wR = 0; chk_rR1 = 0; chk_rR2 = 0;
    req0_wD = 0; req1_wD = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_out", {27'd0, we, wR, wD}, 64'd0);
    chk("reset_busy", busy, 1'b0);

    // reset between accept and the write edge drops the write
    tick(); req0_valid = 1; req0_wR = 3; req0_wD = 5; iss_valid = 1; iss_wR = 3;
    tick(); req0_valid = 0; iss_valid = 0;
    #2; rst_n = 1'b0;
    #1;
    chk("rst_mid_we", we, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("rst_mid_reg3", tb_rf[3], 64'd0);

    // contention: round-robin alternates, fixed priority holds req1 off
    tick(); req0_valid = 1; req0_wR = 1; req0_wD = 32'h11; req1_valid = 1; req1_wR = 2; req1_wD = 32'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant0", req0_ready, (k % 2) == 0);
      chk("rr_grant1", req1_ready, (k % 2) == 1);
      chk("fp_hold1", {d1_r0, d1_r1}, 2'b10);
      if (k > 0) begin
        chk("rr_we", we, 1'b1);
        chk("rr_wR", wR, ((k - 1) % 2 == 0) ? 1 : 2);
        chk("fp_wR_wD", {27'd0, d1_wR, d1_wD}, {27'd0, 5'd1, 32'h11});
      end
      tick();
    end
    req0_valid = 0;
    @(negedge clk);
    chk("rr_we4", {we, wR}, {1'b1, 5'd2});
    chk("fp_release", d1_r1, 1'b1);
    tick(); req1_valid = 0;
    tick();

    // single ALU request
    tick(); req0_valid = 1; req0_wR = 5; req0_wD = 32'hDEADBEEF;
    @(negedge clk); chk("alu_ready", req0_ready, 1'b1);
    tick(); req0_valid = 0;
    @(negedge clk); chk("alu_write", {27'd0, we, wR, wD}, {27'd0, 1'b1, 5'd5, 32'hDEADBEEF});
    tick();
    @(negedge clk); chk("alu_pulse", we, 1'b0);

    // RAW hazard on x7 until the write lands
    tick(); iss_valid = 1; iss_wR = 7; chk_rR1 = 7; chk_rR2 = 3;
    tick(); iss_valid = 0;
    @(negedge clk); chk("haz_stall", stall, 1'b1); chk("haz_fp_stall", d1_stall, 1'b1);
    tick(); req0_valid = 1; req0_wR = 7; req0_wD = 77;
    @(negedge clk); chk("haz_stall_acc", stall, 1'b1);
    tick(); req0_valid = 0;
    @(negedge clk); chk("haz_we", {we, wR, stall}, {1'b1, 5'd7, 1'b1});
    tick();
    @(negedge clk); chk("haz_clear", {stall, busy, d1_busy}, 3'b000);

    // same-edge set/clear on x7: set wins
    tick(); iss_valid = 1; iss_wR = 7; chk_rR1 = 7; chk_rR2 = 0;
    tick(); iss_valid = 0; req0_valid = 1; req0_wR = 7; req0_wD = 1;
    tick(); req0_valid = 0; iss_valid = 1; iss_wR = 7;
    tick(); iss_valid = 0;
    @(negedge clk); chk("collide_pend", {stall, busy}, 2'b11);
    tick(); req0_valid = 1; req0_wR = 7; req0_wD = 2;
    tick(); req0_valid = 0;
    tick();
    @(negedge clk); chk("collide_clear", {stall, busy}, 2'b00);

    // x0: handshake completes, nothing written or pending
    tick(); iss_valid = 1; iss_wR = 0; req0_valid = 1; req0_wR = 0; req0_wD = 9; chk_rR1 = 0;
    @(negedge clk); chk("x0_ready", req0_ready, 1'b1);
    tick(); iss_valid = 0; req0_valid = 0;
    @(negedge clk); chk("x0_we", {we, busy, stall}, 3'b000);
    tick();
    @(negedge clk); chk("x0_busy", busy, 1'b0);

    drive_random(2000);
    tick(); req0_valid = 0; req1_valid = 0; iss_valid = 0;
    repeat (4) tick();
    chk("queue_drained", exp_q.size(), 0);
    chk("fp_idle_we", d1_we, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
